// File: rtl/dll_tx_scheduler_if.sv
// Data Link Layer transmit scheduler bus.
// Replay, DLLP and new-TLP request channels, the output stream and the ack window input.
interface dll_tx_scheduler_if #(
    parameter int PIPE_DATA_WIDTH = 256
);
    logic                       rpl_valid_i;
    logic [PIPE_DATA_WIDTH-1:0] rpl_data_i;
    logic                       rpl_last_i;
    logic [11:0]                rpl_seq_i;
    logic                       rpl_ready_o;

    logic                       dllp_valid_i;
    logic [PIPE_DATA_WIDTH-1:0] dllp_data_i;
    logic                       dllp_ready_o;

    logic                       tlp_valid_i;
    logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
    logic                       tlp_last_i;
    logic                       tlp_ready_o;

    logic [11:0]                ackd_seq_i;

    logic                       out_valid_o;
    logic [PIPE_DATA_WIDTH-1:0] out_data_o;
    logic                       out_sop_o;
    logic                       out_eop_o;
    logic [1:0]                 out_src_o;
    logic [11:0]                out_seq_o;
    logic                       out_ready_i;

    logic [11:0]                next_seq_o;
    logic                       busy_o;

    modport master (
        output rpl_valid_i, rpl_data_i, rpl_last_i, rpl_seq_i,
        input  rpl_ready_o,
        output dllp_valid_i, dllp_data_i,
        input  dllp_ready_o,
        output tlp_valid_i, tlp_data_i, tlp_last_i,
        input  tlp_ready_o,
        output ackd_seq_i,
        input  out_valid_o, out_data_o, out_sop_o, out_eop_o,
        input  out_src_o, out_seq_o,
        output out_ready_i,
        input  next_seq_o, busy_o
    );

    modport slave (
        input  rpl_valid_i, rpl_data_i, rpl_last_i, rpl_seq_i,
        output rpl_ready_o,
        input  dllp_valid_i, dllp_data_i,
        output dllp_ready_o,
        input  tlp_valid_i, tlp_data_i, tlp_last_i,
        output tlp_ready_o,
        input  ackd_seq_i,
        output out_valid_o, out_data_o, out_sop_o, out_eop_o,
        output out_src_o, out_seq_o,
        input  out_ready_i,
        output next_seq_o, busy_o
    );
endinterface

// File: rtl/dll_tx_scheduler.sv
// DLL transmit scheduler: packet-boundary arbitration of replay, DLLP and new TLPs,
// NEXT_TRANSMIT_SEQ ownership and a registered output stage.
module dll_tx_scheduler #(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int MAX_OUTSTANDING = 2048
) (
    input  logic               sclk,
    input  logic               srst_n,
    dll_tx_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REPLAY = 2'd1,
        S_TLP    = 2'd2
    } state_t;

    localparam logic [1:0] SRC_TLP  = 2'd0;
    localparam logic [1:0] SRC_DLLP = 2'd1;
    localparam logic [1:0] SRC_RPL  = 2'd2;

    state_t state;
    state_t state_d;

    logic [11:0] next_seq;
    logic [11:0] outstanding;
    logic        tlp_ok;
    logic        adv;

    logic gnt_rpl;
    logic gnt_dllp;
    logic gnt_tlp;
    logic start;

    logic xfer_rpl;
    logic xfer_dllp;
    logic xfer_tlp;

    logic                       out_valid;
    logic [PIPE_DATA_WIDTH-1:0] out_data;
    logic                       out_sop;
    logic                       out_eop;
    logic [1:0]                 out_src;
    logic [11:0]                out_seq;

    logic                       stg_valid;
    logic [PIPE_DATA_WIDTH-1:0] stg_data;
    logic                       stg_sop;
    logic                       stg_eop;
    logic [1:0]                 stg_src;
    logic [11:0]                stg_seq;

    assign adv = !out_valid || bus.out_ready_i;

    // Modulo-4096 distance from the last acked sequence number.
    assign outstanding = next_seq - bus.ackd_seq_i - 12'd1;
    assign tlp_ok = {1'b0, outstanding} < 13'(MAX_OUTSTANDING);

    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (xfer_rpl && !bus.rpl_last_i) begin
                    state_d = S_REPLAY;
                end else if (xfer_tlp && !bus.tlp_last_i) begin
                    state_d = S_TLP;
                end
            end
            S_REPLAY: begin
                if (xfer_rpl && bus.rpl_last_i) begin
                    state_d = S_IDLE;
                end
            end
            S_TLP: begin
                if (xfer_tlp && bus.tlp_last_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grants exist only while the output stage can take a beat.
    always_comb begin
        gnt_rpl  = 1'b0;
        gnt_dllp = 1'b0;
        gnt_tlp  = 1'b0;
        start    = 1'b0;
        if (srst_n && adv) begin
            unique case (state)
                S_IDLE: begin
                    start = 1'b1;
                    if (bus.rpl_valid_i) begin
                        gnt_rpl = 1'b1;
                    end else if (bus.dllp_valid_i) begin
                        gnt_dllp = 1'b1;
                    end else begin
                        gnt_tlp = bus.tlp_valid_i && tlp_ok;
                    end
                end
                S_REPLAY: gnt_rpl = 1'b1;
                S_TLP:    gnt_tlp = 1'b1;
                default: ;
            endcase
        end
    end

    assign xfer_rpl  = gnt_rpl && bus.rpl_valid_i;
    assign xfer_dllp = gnt_dllp && bus.dllp_valid_i;
    assign xfer_tlp  = gnt_tlp && bus.tlp_valid_i;

    always_comb begin
        stg_valid = 1'b0;
        stg_data  = '0;
        stg_sop   = 1'b0;
        stg_eop   = 1'b0;
        stg_src   = SRC_TLP;
        stg_seq   = '0;
        if (xfer_rpl) begin
            stg_valid = 1'b1;
            stg_data  = bus.rpl_data_i;
            stg_sop   = start;
            stg_eop   = bus.rpl_last_i;
            stg_src   = SRC_RPL;
            stg_seq   = bus.rpl_seq_i;
        end else if (xfer_dllp) begin
            stg_valid = 1'b1;
            stg_data  = bus.dllp_data_i;
            stg_sop   = 1'b1;
            stg_eop   = 1'b1;
            stg_src   = SRC_DLLP;
        end else if (xfer_tlp) begin
            stg_valid = 1'b1;
            stg_data  = bus.tlp_data_i;
            stg_sop   = start;
            stg_eop   = bus.tlp_last_i;
            stg_src   = SRC_TLP;
            stg_seq   = next_seq;
        end
    end

    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_src   <= SRC_TLP;
            out_seq   <= '0;
        end else if (adv) begin
            out_valid <= stg_valid;
            out_data  <= stg_data;
            out_sop   <= stg_sop;
            out_eop   <= stg_eop;
            out_src   <= stg_src;
            out_seq   <= stg_seq;
        end
    end

    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            next_seq <= '0;
        end else if (xfer_tlp && bus.tlp_last_i) begin
            next_seq <= next_seq + 12'd1;
        end
    end

    assign bus.rpl_ready_o  = gnt_rpl;
    assign bus.dllp_ready_o = gnt_dllp;
    assign bus.tlp_ready_o  = gnt_tlp;

    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.out_sop_o   = out_sop;
    assign bus.out_eop_o   = out_eop;
    assign bus.out_src_o   = out_src;
    assign bus.out_seq_o   = out_seq;

    assign bus.next_seq_o = next_seq;
    assign bus.busy_o     = state != S_IDLE;

endmodule

// File: tb/tb_dll_tx_scheduler.sv
// Directed bench for dll_tx_scheduler: arbitration order, framing,
// sequence window, backpressure, wrap and mid-packet reset.
module tb_dll_tx_scheduler;

    localparam int W = 256;

    logic sclk = 1'b0;
    logic srst_n = 1'b0;

    always #5 sclk = ~sclk;

    dll_tx_scheduler_if #(.PIPE_DATA_WIDTH(W)) bus();

    dll_tx_scheduler #(
        .PIPE_DATA_WIDTH(W),
        .MAX_OUTSTANDING(2048)
    ) dut (
        .sclk(sclk),
        .srst_n(srst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [1:0]   src;
        logic [11:0]  seq;
        logic [W-1:0] data;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int passed = 0;

    always @(negedge sclk) begin
        if (srst_n && bus.out_valid_o && bus.out_ready_i) begin
            q.push_back({bus.out_sop_o, bus.out_eop_o, bus.out_src_o,
                         bus.out_seq_o, bus.out_data_o});
        end
    end

    function automatic beat_t mk(input logic sop, input logic eop,
                                 input logic [1:0] src, input logic [11:0] seq,
                                 input logic [31:0] d);
        return {sop, eop, src, seq, W'(d)};
    endfunction

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic tlp_beat(input logic [31:0] d, input logic last);
        int n = 0;
        bus.tlp_valid_i = 1'b1;
        bus.tlp_data_i  = W'(d);
        bus.tlp_last_i  = last;
        forever begin
            @(negedge sclk);
            if (bus.tlp_ready_o) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL tlp_timeout: beat %0h not accepted in 200 cycles", d);
                break;
            end
        end
        step();
    endtask

    task automatic rpl_beat(input logic [31:0] d, input logic last, input logic [11:0] seq);
        int n = 0;
        bus.rpl_valid_i = 1'b1;
        bus.rpl_data_i  = W'(d);
        bus.rpl_last_i  = last;
        bus.rpl_seq_i   = seq;
        forever begin
            @(negedge sclk);
            if (bus.rpl_ready_o) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL rpl_timeout: beat %0h not accepted in 200 cycles", d);
                break;
            end
        end
        step();
    endtask

    task automatic send_tlp(input int nb, input logic [31:0] base);
        for (int i = 0; i < nb; i++) tlp_beat(base + 32'(i), i == nb - 1);
        bus.tlp_valid_i = 1'b0;
        bus.tlp_last_i  = 1'b0;
    endtask

    task automatic send_rpl(input int nb, input logic [31:0] base, input logic [11:0] seq);
        for (int i = 0; i < nb; i++) rpl_beat(base + 32'(i), i == nb - 1, seq);
        bus.rpl_valid_i = 1'b0;
        bus.rpl_last_i  = 1'b0;
    endtask

    task automatic send_dllp(input logic [31:0] d);
        int n = 0;
        bus.dllp_valid_i = 1'b1;
        bus.dllp_data_i  = W'(d);
        forever begin
            @(negedge sclk);
            if (bus.dllp_ready_o) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL dllp_timeout: dllp %0h not accepted in 200 cycles", d);
                break;
            end
        end
        step();
        bus.dllp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.rpl_valid_i  = 1'b0;
        bus.rpl_data_i   = '0;
        bus.rpl_last_i   = 1'b0;
        bus.rpl_seq_i    = '0;
        bus.dllp_valid_i = 1'b0;
        bus.dllp_data_i  = '0;
        bus.tlp_valid_i  = 1'b1;
        bus.tlp_data_i   = '0;
        bus.tlp_last_i   = 1'b1;
        bus.ackd_seq_i   = 12'd4095;
        bus.out_ready_i  = 1'b1;
        srst_n = 1'b0;
        repeat (3) step();
        @(negedge sclk);
        if (bus.out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); else passed++;
        checks++;
        if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else passed++;
        checks++;
        if (bus.next_seq_o !== 12'd0) $display("FAIL reset_next_seq: got %0d want 0", bus.next_seq_o); else passed++;
        checks++;
        if (bus.tlp_ready_o !== 1'b0) $display("FAIL reset_tlp_ready: got %b want 0", bus.tlp_ready_o); else passed++;
        checks++;
        if ({bus.out_sop_o, bus.out_eop_o, bus.out_src_o, bus.out_seq_o} !== 16'd0)
            $display("FAIL reset_out_fields: got %0h want 0",
                     {bus.out_sop_o, bus.out_eop_o, bus.out_src_o, bus.out_seq_o});
        else passed++;
        checks++;
        bus.tlp_valid_i = 1'b0;
        bus.tlp_last_i  = 1'b0;
        step();
        srst_n = 1'b1;
        repeat (2) step();
        q.delete();
    endtask

    task automatic check_beats(input string name, input beat_t exp[$]);
        beat_t g;
        if (q.size() !== exp.size()) $display("FAIL %s_count: got %0d beats want %0d", name, q.size(), exp.size()); else passed++;
        checks++;
        for (int i = 0; i < exp.size(); i++) begin
            g = (q.size() > 0) ? q.pop_front() : '1;
            if (g !== exp[i])
                $display("FAIL %s_beat%0d: got sop%b eop%b src%0d seq%0d data%0h want sop%b eop%b src%0d seq%0d data%0h",
                         name, i, g.sop, g.eop, g.src, g.seq, g.data[31:0],
                         exp[i].sop, exp[i].eop, exp[i].src, exp[i].seq, exp[i].data[31:0]);
            else passed++;
            checks++;
        end
        q.delete();
    endtask

    task automatic test_basic_tlp();
        send_tlp(3, 32'h100);
        repeat (3) step();
        check_beats("basic", '{mk(1, 0, 0, 0, 32'h100), mk(0, 0, 0, 0, 32'h101),
                               mk(0, 1, 0, 0, 32'h102)});
        @(negedge sclk);
        if (bus.next_seq_o !== 12'd1) $display("FAIL basic_next_seq: got %0d want 1", bus.next_seq_o); else passed++;
        checks++;
        step();
    endtask

    task automatic test_priority();
        fork
            send_rpl(2, 32'h200, 12'd7);
            send_dllp(32'h300);
            send_tlp(2, 32'h400);
        join
        repeat (3) step();
        check_beats("priority", '{mk(1, 0, 2, 7, 32'h200), mk(0, 1, 2, 7, 32'h201),
                                  mk(1, 1, 1, 0, 32'h300),
                                  mk(1, 0, 0, 1, 32'h400), mk(0, 1, 0, 1, 32'h401)});
        @(negedge sclk);
        if (bus.next_seq_o !== 12'd2) $display("FAIL priority_next_seq: got %0d want 2", bus.next_seq_o); else passed++;
        checks++;
        step();
    endtask

    task automatic test_no_interleave();
        fork
            send_tlp(4, 32'h500);
            begin
                step();
                send_dllp(32'h600);
            end
        join
        repeat (3) step();
        check_beats("interleave", '{mk(1, 0, 0, 2, 32'h500), mk(0, 0, 0, 2, 32'h501),
                                    mk(0, 0, 0, 2, 32'h502), mk(0, 1, 0, 2, 32'h503),
                                    mk(1, 1, 1, 0, 32'h600)});
        @(negedge sclk);
        if (bus.next_seq_o !== 12'd3) $display("FAIL interleave_next_seq: got %0d want 3", bus.next_seq_o); else passed++;
        checks++;
        step();
    endtask

    task automatic test_window();
        int cnt = 0;
        srst_n = 1'b0;
        step();
        srst_n = 1'b1;
        bus.ackd_seq_i  = 12'd4095;
        bus.tlp_valid_i = 1'b1;
        bus.tlp_last_i  = 1'b1;
        bus.tlp_data_i  = W'(32'h7000);
        for (int c = 0; c < 2100; c++) begin
            @(negedge sclk);
            if (bus.tlp_ready_o) cnt++;
            step();
        end
        if (cnt !== 2048) $display("FAIL window_fill: got %0d transfers want 2048", cnt); else passed++;
        checks++;
        @(negedge sclk);
        if (bus.tlp_ready_o !== 1'b0) $display("FAIL window_closed_ready: got %b want 0", bus.tlp_ready_o); else passed++;
        checks++;
        if (bus.next_seq_o !== 12'd2048) $display("FAIL window_next_seq: got %0d want 2048", bus.next_seq_o); else passed++;
        checks++;
        step();
        q.delete();
        bus.ackd_seq_i = 12'd0;
        @(negedge sclk);
        if (bus.tlp_ready_o !== 1'b1) $display("FAIL window_open_ready: got %b want 1", bus.tlp_ready_o); else passed++;
        checks++;
        step();
        bus.tlp_valid_i = 1'b0;
        bus.tlp_last_i  = 1'b0;
        repeat (3) step();
        check_beats("window", '{mk(1, 1, 0, 2048, 32'h7000)});
    endtask

    task automatic test_wrap_backpressure();
        int cnt = 0;
        int bad = 0;
        bus.ackd_seq_i  = 12'd2047;
        bus.tlp_valid_i = 1'b1;
        bus.tlp_last_i  = 1'b1;
        bus.tlp_data_i  = W'(32'h7100);
        for (int c = 0; c < 2200; c++) begin
            @(negedge sclk);
            if (bus.tlp_ready_o) cnt++;
            step();
            if (cnt == 2046) break;
        end
        bus.tlp_valid_i = 1'b0;
        bus.tlp_last_i  = 1'b0;
        repeat (3) step();
        q.delete();
        @(negedge sclk);
        if (bus.next_seq_o !== 12'd4095) $display("FAIL wrap_pre_seq: got %0d want 4095", bus.next_seq_o); else passed++;
        checks++;
        step();
        tlp_beat(32'h800, 1'b0);
        bus.out_ready_i = 1'b0;
        bus.tlp_data_i  = W'(32'h801);
        bus.tlp_last_i  = 1'b0;
        repeat (5) begin
            @(negedge sclk);
            if (bus.tlp_ready_o || !bus.out_valid_o || !bus.out_sop_o
                || bus.out_data_o != W'(32'h800) || bus.out_seq_o != 12'd4095)
                bad++;
            step();
        end
        if (bad !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); else passed++;
        checks++;
        bus.out_ready_i = 1'b1;
        tlp_beat(32'h801, 1'b0);
        tlp_beat(32'h802, 1'b1);
        bus.tlp_valid_i = 1'b0;
        bus.tlp_last_i  = 1'b0;
        repeat (3) step();
        check_beats("wrap", '{mk(1, 0, 0, 4095, 32'h800), mk(0, 0, 0, 4095, 32'h801),
                              mk(0, 1, 0, 4095, 32'h802)});
        @(negedge sclk);
        if (bus.next_seq_o !== 12'd0) $display("FAIL wrap_next_seq: got %0d want 0", bus.next_seq_o); else passed++;
        checks++;
        step();
    endtask

    task automatic test_reset_mid_replay();
        bus.ackd_seq_i = 12'd4095;
        send_tlp(1, 32'ha00);
        repeat (2) step();
        rpl_beat(32'hb00, 1'b0, 12'd5);
        bus.rpl_data_i = W'(32'hb01);
        @(negedge sclk);
        if (bus.busy_o !== 1'b1) $display("FAIL replay_busy: got %b want 1", bus.busy_o); else passed++;
        checks++;
        srst_n = 1'b0;
        step();
        srst_n = 1'b1;
        bus.rpl_valid_i = 1'b0;
        bus.rpl_last_i  = 1'b0;
        @(negedge sclk);
        if (bus.out_valid_o !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid_o); else passed++;
        checks++;
        if (bus.busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy_o); else passed++;
        checks++;
        if (bus.next_seq_o !== 12'd0) $display("FAIL rst_mid_next_seq: got %0d want 0", bus.next_seq_o); else passed++;
        checks++;
        q.delete();
        step();
        send_dllp(32'hc00);
        repeat (3) step();
        check_beats("post_reset_dllp", '{mk(1, 1, 1, 0, 32'hc00)});
    endtask

    initial begin
        test_reset();
        test_basic_tlp();
        test_priority();
        test_no_interleave();
        test_window();
        test_wrap_backpressure();
        test_reset_mid_replay();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
